cpu_bus_master: RTL and testbench

Initiator end of the NES CPU cartridge bus. It generates free-running M2 cycles and issues queued read/write transactions (address, R/W, /ROMSEL, data) toward mapper chips. Used to drive mapper register programming, for example 8000/8001/A000/A001/C000-E001 sequences. Sits between the host/command logic and the mapper's cpu_* inputs, and also serves as the bus driver in mapper benches.

---
 rtl/cpu_bus_master.sv | 157 +++++++++++++++
 tb/tb_cpu_bus_master.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_bus_master.sv
// NES CPU cartridge bus initiator: free-running M2 plus in-order queued read/write cycles.
// Optional `CPU_M3_EN adds a one-clk mid-phi2 M3 strobe on cpu_m3.
module cpu_bus_master #(
  parameter int M2_LO      = 4,
  parameter int M2_HI      = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_rw,
  input  logic [15:0] cmd_addr,
  input  logic [7:0]  cmd_data,
  output logic        rsp_valid,
  output logic [7:0]  rsp_data,
  output logic        busy,
  output logic        cpu_m2,
  output logic        cpu_rw,
  output logic [15:0] cpu_addr,
  output logic        cpu_ce_n,
  output logic [7:0]  cpu_dout,
  output logic        cpu_dout_oe,
  input  logic [7:0]  cpu_din,
  output logic        cpu_m3
);
  localparam int PER = M2_LO + M2_HI;
  localparam int PW  = $clog2(PER);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam logic [PW-1:0] PH_LAST  = PW'(PER - 1);
  localparam logic [PW-1:0] PH_HI    = PW'(M2_LO);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(FIFO_DEPTH);

  typedef struct packed {
    logic        rw;
    logic [15:0] addr;
    logic [7:0]  data;
  } cmd_t;

  cmd_t          mem [FIFO_DEPTH];
  cmd_t          head;
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [PW-1:0] ph_q, ph_d;
  logic          push, pop, boundary;
  logic          cur_real_q, cur_real_d;
  logic [7:0]    cur_data_q, cur_data_d;
  logic          cpu_m2_q, cpu_m2_d, cpu_rw_q, cpu_rw_d, cpu_ce_n_q, cpu_ce_n_d;
  logic [15:0]   cpu_addr_q, cpu_addr_d;
  logic [7:0]    cpu_dout_q, cpu_dout_d, rsp_data_q, rsp_data_d;
  logic          cpu_dout_oe_q, cpu_dout_oe_d, rsp_valid_q, rsp_valid_d;
  logic          busy_q, busy_d, cmd_ready_q, cmd_ready_d;

  // Outputs are computed from the next phase so every registered output lines up with ph_q.
  always_comb begin
    push     = cmd_valid & cmd_ready_q;
    boundary = (ph_q == PH_LAST);
    pop      = boundary & (cnt_q != '0);
    ph_d     = boundary ? '0 : ph_q + PW'(1);
    head     = mem[rd_q];
    wr_d     = push ? wr_q + AW'(1) : wr_q;
    rd_d     = pop ? rd_q + AW'(1) : rd_q;
    cnt_d    = cnt_q;
    if (push && !pop) cnt_d = cnt_q + (AW+1)'(1);
    else if (pop && !push) cnt_d = cnt_q - (AW+1)'(1);

    cur_real_d = cur_real_q;
    cur_data_d = cur_data_q;
    cpu_rw_d   = cpu_rw_q;
    cpu_addr_d = cpu_addr_q;
    if (boundary) begin
      cur_real_d = pop;
      cpu_rw_d   = pop ? head.rw : 1'b1;
      cpu_addr_d = pop ? head.addr : 16'h0000;
      if (pop) cur_data_d = head.data;
    end

    cpu_m2_d      = (ph_d >= PH_HI);
    cpu_ce_n_d    = ~(cpu_addr_d[15] & cpu_m2_d);
    cpu_dout_oe_d = (ph_d != '0) & ~cpu_rw_d;
    cpu_dout_d    = ((ph_d == PW'(1)) && !cpu_rw_d) ? cur_data_d : cpu_dout_q;
    // A real read samples the bus on its last phi2 clk; dummy reads never respond.
    rsp_valid_d   = boundary & cur_real_q & cpu_rw_q;
    rsp_data_d    = rsp_valid_d ? cpu_din : rsp_data_q;
    busy_d        = (cnt_d != '0) | cur_real_d;
    cmd_ready_d   = (cnt_d != CNT_FULL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph_q          <= '0;
      wr_q          <= '0;
      rd_q          <= '0;
      cnt_q         <= '0;
      cur_real_q    <= 1'b0;
      cpu_m2_q      <= 1'b0;
      cpu_rw_q      <= 1'b1;
      cpu_addr_q    <= 16'h0000;
      cpu_ce_n_q    <= 1'b1;
      cpu_dout_q    <= 8'h00;
      cpu_dout_oe_q <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= 8'h00;
      busy_q        <= 1'b0;
      cmd_ready_q   <= 1'b1;
    end else begin
      ph_q          <= ph_d;
      wr_q          <= wr_d;
      rd_q          <= rd_d;
      cnt_q         <= cnt_d;
      cur_real_q    <= cur_real_d;
      cpu_m2_q      <= cpu_m2_d;
      cpu_rw_q      <= cpu_rw_d;
      cpu_addr_q    <= cpu_addr_d;
      cpu_ce_n_q    <= cpu_ce_n_d;
      cpu_dout_q    <= cpu_dout_d;
      cpu_dout_oe_q <= cpu_dout_oe_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_data_q    <= rsp_data_d;
      busy_q        <= busy_d;
      cmd_ready_q   <= cmd_ready_d;
    end
  end

  // Command storage and the in-flight write data carry no reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_q] <= '{rw: cmd_rw, addr: cmd_addr, data: cmd_data};
    cur_data_q <= cur_data_d;
  end

`ifdef CPU_M3_EN
  localparam logic [PW-1:0] PH_M3 = PW'(M2_LO + M2_HI / 2);
  logic cpu_m3_q, cpu_m3_d;

  always_comb cpu_m3_d = (ph_d == PH_M3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cpu_m3_q <= 1'b0;
    else        cpu_m3_q <= cpu_m3_d;
  end

  assign cpu_m3 = cpu_m3_q;
`else
  assign cpu_m3 = 1'b0;
`endif

  assign cmd_ready   = cmd_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign busy        = busy_q;
  assign cpu_m2      = cpu_m2_q;
  assign cpu_rw      = cpu_rw_q;
  assign cpu_addr    = cpu_addr_q;
  assign cpu_ce_n    = cpu_ce_n_q;
  assign cpu_dout    = cpu_dout_q;
  assign cpu_dout_oe = cpu_dout_oe_q;
endmodule

// File: tb/tb_cpu_bus_master.sv
// Randomized bench for cpu_bus_master against a queue-based transaction model of the bus.
module tb_cpu_bus_master;
  localparam int M2_LO = 4, M2_HI = 4, FIFO_DEPTH = 4, PER = M2_LO + M2_HI;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0, cmd_rw = 1'b0;
  logic [15:0] cmd_addr = 16'h0;
  logic [7:0]  cmd_data = 8'h0, cpu_din = 8'h0;
  logic        cmd_ready, rsp_valid, busy, cpu_m2, cpu_rw, cpu_ce_n, cpu_dout_oe, cpu_m3;
  logic [7:0]  rsp_data, cpu_dout;
  logic [15:0] cpu_addr;

  int vectors = 0, miscompares = 0;
  bit din_fixed = 1'b0;

  cpu_bus_master #(.M2_LO(M2_LO), .M2_HI(M2_HI), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_rw(cmd_rw), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy),
    .cpu_m2(cpu_m2), .cpu_rw(cpu_rw), .cpu_addr(cpu_addr), .cpu_ce_n(cpu_ce_n),
    .cpu_dout(cpu_dout), .cpu_dout_oe(cpu_dout_oe), .cpu_din(cpu_din), .cpu_m3(cpu_m3)
  );

  always #5 clk = ~clk;

  wire [39:0] dut_all = {cpu_m2, cpu_rw, cpu_addr, cpu_ce_n, cpu_dout, cpu_dout_oe,
                         rsp_valid, rsp_data, cpu_m3, busy, cmd_ready};
  localparam logic [39:0] RST_ALL = {1'b0, 1'b1, 16'h0000, 1'b1, 8'h00, 1'b0,
                                     1'b0, 8'h00, 1'b0, 1'b0, 1'b1};

  // Reference model: a command queue, the current bus cycle, and a phase position.
  typedef struct {logic rw; logic [15:0] addr; logic [7:0] data;} cmd_t;
  cmd_t        mq[$];
  cmd_t        mc;
  int          m_ph;
  logic        m_real, m_rw, m_acc;
  logic [15:0] m_addr;
  logic [7:0]  m_data, e_dout, e_rsp_data;
  logic        e_m2, e_ce_n, e_oe, e_rsp_valid, e_busy, e_ready, e_m3;
  logic [39:0] e_all;

  initial forever begin
    @(posedge clk);
    #1 cpu_din = din_fixed ? 8'h5A : 8'($urandom);
  end

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_ph = 0; mq.delete(); m_real = 1'b0; m_rw = 1'b1; m_addr = 16'h0; m_data = 8'h0;
      e_dout = 8'h0; e_rsp_valid = 1'b0; e_rsp_data = 8'h0;
    end else begin
      m_acc = cmd_valid && (mq.size() < FIFO_DEPTH);
      e_rsp_valid = 1'b0;
      if (m_ph == PER - 1) begin
        if (m_real && m_rw) begin
          e_rsp_valid = 1'b1;
          e_rsp_data  = cpu_din;
        end
        if (mq.size() > 0) begin
          mc = mq.pop_front();
          m_real = 1'b1; m_rw = mc.rw; m_addr = mc.addr; m_data = mc.data;
        end else begin
          m_real = 1'b0; m_rw = 1'b1; m_addr = 16'h0;
        end
        m_ph = 0;
      end else begin
        m_ph = m_ph + 1;
      end
      if (m_acc) mq.push_back('{rw: cmd_rw, addr: cmd_addr, data: cmd_data});
      if (m_ph == 1 && m_real && !m_rw) e_dout = m_data;
    end
    e_m2    = (m_ph >= M2_LO);
    e_ce_n  = !(m_addr[15] && e_m2);
    e_oe    = m_real && !m_rw && (m_ph != 0);
    e_busy  = (mq.size() > 0) || m_real;
    e_ready = (mq.size() < FIFO_DEPTH);
`ifdef CPU_M3_EN
    e_m3    = (m_ph == M2_LO + M2_HI / 2);
`else
    e_m3    = 1'b0;
`endif
    e_all = {e_m2, m_rw, m_addr, e_ce_n, e_dout, e_oe, e_rsp_valid, e_rsp_data, e_m3, e_busy, e_ready};
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time %0t exceeded limit", $time);
    $fatal(1, "watchdog");
  end

  // Waits for model phase p at a falling edge, then leaves the caller just after the next rising edge.
  task automatic wait_ph(input int p);
    int n = 0;
    do begin @(negedge clk); n++; end while (m_ph != p && n < 40);
    @(posedge clk); #1;
  endtask

  // Caller must be positioned just after a rising edge.
  task automatic send(input logic rw, input logic [15:0] a, input logic [7:0] d);
    bit got = 1'b0;
    int n = 0;
    cmd_rw = rw; cmd_addr = a; cmd_data = d; cmd_valid = 1'b1;
    while (!got && n < 64) begin
      @(negedge clk);
      got = cmd_ready;
      n++;
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    vectors++;
    if (!got) begin
      miscompares++;
      $display("FAIL send_accept: cmd_ready got %b required 1 for addr %h", cmd_ready, a);
    end
  endtask

  task automatic test_reset;
    repeat (3) begin
      @(negedge clk);
      vectors++;
      if (dut_all !== RST_ALL) begin
        miscompares++;
        $display("FAIL reset_values: got %h required %h", dut_all, RST_ALL);
      end
    end
    @(negedge clk); #2 rst_n = 1'b1;
  endtask

  task automatic test_idle;
    int highs = 0;
    repeat (24) begin
      @(negedge clk);
      if (cpu_m2) highs++;
      vectors++;
      if (dut_all !== e_all) begin
        miscompares++;
        $display("FAIL idle_bus: got %h required %h", dut_all, e_all);
      end
      vectors++;
      if ({cpu_rw, cpu_addr, cpu_ce_n, rsp_valid, busy} !== {1'b1, 16'h0, 1'b1, 1'b0, 1'b0}) begin
        miscompares++;
        $display("FAIL idle_dummy: rw %b addr %h ce_n %b rsp %b busy %b required 1 0000 1 0 0",
                 cpu_rw, cpu_addr, cpu_ce_n, rsp_valid, busy);
      end
    end
    vectors++;
    if (highs != 12) begin
      miscompares++;
      $display("FAIL idle_m2_duty: got %0d high clks required 12", highs);
    end
  endtask

  task automatic test_writes;
    logic [24:0] seen[$];
    wait_ph(2);
    send(1'b0, 16'h8000, 8'h06);
    send(1'b0, 16'h8001, 8'h03);
    repeat (24) begin
      @(negedge clk);
      if (m_ph == 2 && m_real) seen.push_back({cpu_rw, cpu_addr, cpu_dout});
      vectors++;
      if (dut_all !== e_all) begin
        miscompares++;
        $display("FAIL write_bus: got %h required %h", dut_all, e_all);
      end
    end
    vectors++;
    if (seen.size() != 2 || seen[0] !== {1'b0, 16'h8000, 8'h06} || seen[1] !== {1'b0, 16'h8001, 8'h03}) begin
      miscompares++;
      $display("FAIL write_sequence: got %0d cycles first %h required 2 cycles 0800006 0800103",
               seen.size(), (seen.size() > 0) ? seen[0] : 25'h0);
    end
    vectors++;
    if (cpu_dout_oe !== 1'b0) begin
      miscompares++;
      $display("FAIL write_oe_release: got %b required 0", cpu_dout_oe);
    end
  endtask

  task automatic test_read;
    int pulses = 0;
    din_fixed = 1'b1;
    wait_ph(2);
    send(1'b1, 16'hC000, 8'h00);
    repeat (24) begin
      @(negedge clk);
      if (rsp_valid) pulses++;
      vectors++;
      if (dut_all !== e_all) begin
        miscompares++;
        $display("FAIL read_bus: got %h required %h", dut_all, e_all);
      end
    end
    vectors++;
    if (pulses != 1 || rsp_data !== 8'h5A) begin
      miscompares++;
      $display("FAIL read_rsp: got %0d pulses data %h required 1 pulse data 5a", pulses, rsp_data);
    end
    din_fixed = 1'b0;
  endtask

  task automatic test_back_to_back;
    logic [15:0] sent[6];
    logic [15:0] seen[$];
    int ready_low = 0;
    int first = -1;
    bit ok = 1'b1;
    wait_ph(2);
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          sent[i] = 16'($urandom) | 16'h0001;
          send(1'($urandom), sent[i], 8'($urandom));
        end
      end
      begin
        repeat (64) begin
          @(negedge clk);
          if (!cmd_ready) ready_low++;
          if (m_ph == 2) seen.push_back(cpu_addr);
          vectors++;
          if (dut_all !== e_all) begin
            miscompares++;
            $display("FAIL b2b_bus: got %h required %h", dut_all, e_all);
          end
        end
      end
    join
    for (int i = 0; i < seen.size(); i++) if (first < 0 && seen[i] != 16'h0) first = i;
    if (first < 0 || first + 6 > seen.size()) ok = 1'b0;
    else for (int i = 0; i < 6; i++) if (seen[first + i] !== sent[i]) ok = 1'b0;
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL b2b_order: first real cycle index %0d of %0d, first addr %h required %h",
               first, seen.size(), (first >= 0) ? seen[first] : 16'h0, sent[0]);
    end
    vectors++;
    if (ready_low == 0) begin
      miscompares++;
      $display("FAIL b2b_ready_drop: got %0d clks with cmd_ready low required >0", ready_low);
    end
  endtask

  task automatic test_random;
    bit done = 1'b0;
    int n = 0;
    @(posedge clk); #1;
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          repeat ($urandom_range(0, 12)) begin @(posedge clk); #1; end
          send(1'($urandom), 16'($urandom), 8'($urandom));
        end
        done = 1'b1;
      end
      begin
        while ((!done || e_busy) && n < 3000) begin
          @(negedge clk);
          n++;
          vectors++;
          if (dut_all !== e_all) begin
            miscompares++;
            $display("FAIL random_bus: got %h required %h at %0t", dut_all, e_all, $time);
          end
        end
      end
    join
    vectors++;
    if (n >= 3000) begin
      miscompares++;
      $display("FAIL random_drain: busy got %b after %0d clks required 0", busy, n);
    end
  endtask

  task automatic test_m3;
    int highs = 0;
    int req;
    logic exp_m3;
`ifdef CPU_M3_EN
    req = 2;
`else
    req = 0;
`endif
    repeat (16) begin
      @(negedge clk);
`ifdef CPU_M3_EN
      exp_m3 = (m_ph == 6);
`else
      exp_m3 = 1'b0;
`endif
      if (cpu_m3) highs++;
      vectors++;
      if (cpu_m3 !== exp_m3) begin
        miscompares++;
        $display("FAIL m3_strobe: got %b required %b at phase %0d", cpu_m3, exp_m3, m_ph);
      end
    end
    vectors++;
    if (highs != req) begin
      miscompares++;
      $display("FAIL m3_count: got %0d pulses required %0d", highs, req);
    end
  endtask

  task automatic test_reset_mid;
    int n = 0;
    wait_ph(2);
    send(1'b0, 16'hA001, 8'h5C);
    send(1'b1, 16'h8000, 8'h00);
    do begin @(negedge clk); n++; end
    while (!(m_real && m_addr == 16'hA001 && m_ph == 5) && n < 40);
    vectors++;
    if (n >= 40) begin
      miscompares++;
      $display("FAIL rstmid_reach: addr %h got no phi2 clk 2 of A001 write required one", cpu_addr);
    end
    #1 rst_n = 1'b0;
    #1;
    vectors++;
    if (dut_all !== RST_ALL) begin
      miscompares++;
      $display("FAIL rstmid_async: got %h required %h", dut_all, RST_ALL);
    end
    @(negedge clk); #2 rst_n = 1'b1;
    repeat (16) begin
      @(negedge clk);
      vectors++;
      if ({cpu_m2, cpu_rw, cpu_addr, busy, rsp_valid, cpu_dout_oe} !== {e_m2, 1'b1, 16'h0, 1'b0, 1'b0, 1'b0}) begin
        miscompares++;
        $display("FAIL rstmid_after: m2 %b rw %b addr %h busy %b rsp %b oe %b required %b 1 0000 0 0 0",
                 cpu_m2, cpu_rw, cpu_addr, busy, rsp_valid, cpu_dout_oe, e_m2);
      end
    end
  endtask

  initial begin
    test_reset;
    test_idle;
    test_writes;
    test_read;
    test_back_to_back;
    test_random;
    test_m3;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
